// File: rtl/fir_sched_pkg.sv
// Shared state encoding and default sizing for the FIR sample scheduler.
// Used by fir_sample_sched and fir_tap_counter.
package fir_sched_pkg;

  localparam int STATE_W      = 3;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_TAPS = 16;
  localparam int DEF_RD_LAT   = 1;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    MAC   = 3'd4,
    VALID = 3'd5
  } state_t;

  // Tap index width; a single-tap filter still needs a 1-bit index port.
  function automatic int tap_width(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_tap_counter.sv
// Tap index counter: synchronous clear, count enable, stops at NUM_TAPS-1
// and flags that terminal value so the scheduler can leave the MAC phase.
module fir_tap_counter
  import fir_sched_pkg::*;
#(
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int TAP_W    = tap_width(NUM_TAPS)
) (
  input  logic             clk_rd,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [TAP_W-1:0] count,
  output logic             tc
);

  localparam logic [TAP_W-1:0] LAST = TAP_W'(NUM_TAPS - 1);

  assign tc = (count == LAST);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + TAP_W'(1);
    end
  end

endmodule

// File: rtl/fir_sample_sched.sv
// Read-domain scheduler: pops one FIFO sample, loads the delay line, runs NUM_TAPS
// MAC cycles and offers the result on a valid/ready handshake. Define
// FIR_SCHED_STATS_EN to add the smp_count / stall_count statistics ports.
module fir_sample_sched
  import fir_sched_pkg::*;
#(
  parameter int  DATA_W   = DEF_DATA_W,
  parameter int  NUM_TAPS = DEF_NUM_TAPS,
  parameter int  RD_LAT   = DEF_RD_LAT,
  localparam int TAP_W    = tap_width(NUM_TAPS)
) (
  input  logic              clk_rd,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic [DATA_W-1:0] smp_data,
  output logic              smp_load,
  output logic              mac_clr,
  output logic              mac_en,
  output logic [TAP_W-1:0]  tap_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [15:0]       smp_count,
  output logic [15:0]       stall_count
`endif
);

  state_t     state, state_nxt;
  logic [1:0] wait_cnt;
  logic       wait_done;
  logic       start;
  logic       accept;
  logic       tap_tc;

  assign start     = enable && !fifo_empty;
  assign accept    = (state == VALID) && out_ready;
  assign wait_done = (wait_cnt == 2'(RD_LAT - 1));

  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches are inferred.
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    smp_load   = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    out_valid  = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE:  if (start) state_nxt = POP;
      POP: begin
        fifo_rd_en = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT:  if (wait_done) state_nxt = LOAD;
      LOAD: begin
        smp_load  = 1'b1;
        mac_clr   = 1'b1;
        state_nxt = MAC;
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap_tc) state_nxt = VALID;
      end
      VALID: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = start ? POP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pop-to-data latency; runs only while in WAIT.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (state == WAIT && !wait_done) begin
      wait_cnt <= wait_cnt + 2'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Captured on the last WAIT cycle so smp_data is already valid while smp_load is high.
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      smp_data <= '0;
    end else if (state == WAIT && wait_done) begin
      smp_data <= fifo_rd_data;
    end
  end

  fir_tap_counter #(
    .NUM_TAPS (NUM_TAPS),
    .TAP_W    (TAP_W)
  ) u_tap_counter (
    .clk_rd (clk_rd),
    .rst    (rst),
    .clr    (((state != MAC) && (state != VALID)) || accept),
    .en     (state == MAC),
    .count  (tap_idx),
    .tc     (tap_tc)
  );

`ifdef FIR_SCHED_STATS_EN
  always_ff @(posedge clk_rd or posedge rst) begin
    if (rst) begin
      smp_count   <= '0;
      stall_count <= '0;
    end else begin
      if (accept && smp_count != 16'hFFFF) smp_count <= smp_count + 16'd1;
      if (state == VALID && !out_ready && stall_count != 16'hFFFF) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_sample_sched.sv
// Self-checking bench for fir_sample_sched: a timeline model checks the default
// instance every cycle; a second instance (RD_LAT=2, NUM_TAPS=1) gets directed checks.
module tb_fir_sample_sched;

  localparam int NUM_TAPS = 16;
  localparam int RD_LAT   = 1;
  localparam int K_LOAD   = 2 + RD_LAT;
  localparam int K_MAC0   = 3 + RD_LAT;
  localparam int K_VALID  = 3 + RD_LAT + NUM_TAPS;

  logic        clk_rd = 1'b0;
  logic        rst;
  always #5 clk_rd = ~clk_rd;

  logic        enable, fifo_empty, fifo_rd_en, smp_load, mac_clr, mac_en;
  logic        out_valid, out_ready, busy;
  logic [15:0] fifo_rd_data, smp_data;
  logic [3:0]  tap_idx;

  logic        b_enable, b_empty, b_rd_en, b_load, b_clr, b_mac_en, b_valid, b_busy;
  logic        b_ready;
  logic [15:0] b_rd_data, b_smp;
  logic [0:0]  b_tap;

`ifdef FIR_SCHED_STATS_EN
  logic [15:0] smp_count, stall_count, b_smp_count, b_stall_count;
`endif

  fir_sample_sched u_dut (
    .clk_rd(clk_rd), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .smp_data(smp_data),
    .smp_load(smp_load), .mac_clr(mac_clr), .mac_en(mac_en), .tap_idx(tap_idx),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FIR_SCHED_STATS_EN
    , .smp_count(smp_count), .stall_count(stall_count)
`endif
  );

  fir_sample_sched #(.DATA_W(16), .NUM_TAPS(1), .RD_LAT(2)) u_dut_b (
    .clk_rd(clk_rd), .rst(rst), .enable(b_enable), .fifo_empty(b_empty),
    .fifo_rd_en(b_rd_en), .fifo_rd_data(b_rd_data), .smp_data(b_smp),
    .smp_load(b_load), .mac_clr(b_clr), .mac_en(b_mac_en), .tap_idx(b_tap),
    .out_valid(b_valid), .out_ready(b_ready), .busy(b_busy)
`ifdef FIR_SCHED_STATS_EN
    , .smp_count(b_smp_count), .stall_count(b_stall_count)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model and reference bookkeeping
  logic [15:0] q[$];
  logic [15:0] sent[$];
  logic        pop_pending = 1'b0;

  task automatic push(input logic [15:0] w);
    q.push_back(w);
    sent.push_back(w);
    fifo_empty = 1'b0;
  endtask

  always @(posedge clk_rd) begin
    #1;
    if (pop_pending) begin
      check("pop_while_empty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) fifo_rd_data = q.pop_front();
      fifo_empty = (q.size() == 0);
    end
  end

  // Timeline model: k = cycles since the pop cycle (k=1), 0 when idle, saturates at K_VALID.
  int          k = 0;
  int          cyc = 0;
  int          n_pop = 0;
  int          mac_cnt = 0;
  int          last_mac_tap = -1;
  int          load_cyc = -1;
  int          valid_rise_cyc = -1;
  int          pop_cycs[$];
  logic [15:0] load_log[$];
  logic [15:0] cur_word = '0;
  logic [15:0] exp_smp = '0;
  logic        prev_valid = 1'b0;
  int          exp_acc = 0;
  int          exp_stall = 0;
  int          e_tap;

  always @(negedge clk_rd) begin
    cyc++;
    if (rst) begin
      k = 0; exp_smp = '0; exp_acc = 0; exp_stall = 0;
      prev_valid = 1'b0; pop_pending = 1'b0;
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_mac_en", 32'(mac_en), 32'd0);
      check("rst_smp", 32'(smp_data), 32'd0);
      check("rst_tap", 32'(tap_idx), 32'd0);
    end else begin
      if (k == 1) begin
        if (n_pop < sent.size()) cur_word = sent[n_pop];
        n_pop++;
      end
      if (k == K_LOAD) exp_smp = cur_word;
      if (k >= K_VALID) e_tap = NUM_TAPS - 1;
      else if (k >= K_MAC0) e_tap = k - K_MAC0;
      else e_tap = 0;
      check("rd_en", 32'(fifo_rd_en), 32'(k == 1));
      check("smp_load", 32'(smp_load), 32'(k == K_LOAD));
      check("mac_clr", 32'(mac_clr), 32'(k == K_LOAD));
      check("mac_en", 32'(mac_en), 32'(k >= K_MAC0 && k < K_VALID));
      check("tap_idx", 32'(tap_idx), 32'(e_tap));
      check("out_valid", 32'(out_valid), 32'(k >= K_VALID));
      check("busy", 32'(busy), 32'(k != 0));
      check("smp_data", 32'(smp_data), 32'(exp_smp));
`ifdef FIR_SCHED_STATS_EN
      check("smp_count", 32'(smp_count), 32'(exp_acc));
      check("stall_count", 32'(stall_count), 32'(exp_stall));
`endif
      if (fifo_rd_en) pop_cycs.push_back(cyc);
      if (smp_load) begin load_cyc = cyc; load_log.push_back(smp_data); end
      if (mac_en) begin mac_cnt++; last_mac_tap = int'(tap_idx); end
      if (out_valid && !prev_valid) valid_rise_cyc = cyc;
      prev_valid  = out_valid;
      pop_pending = fifo_rd_en;

      if (k == 0) begin
        k = (enable && !fifo_empty) ? 1 : 0;
      end else if (k >= K_VALID) begin
        if (out_ready) begin
          if (exp_acc < 16'hFFFF) exp_acc++;
          k = (enable && !fifo_empty) ? 1 : 0;
        end else if (exp_stall < 16'hFFFF) begin
          exp_stall++;
        end
      end else begin
        k++;
      end
    end
  end

  task automatic wait_valid(input string tag);
    int i = 0;
    while (!out_valid && i < 200) begin @(negedge clk_rd); i++; end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_mac(input string tag);
    int i = 0;
    while (!mac_en && i < 200) begin @(negedge clk_rd); i++; end
    check(tag, 32'(mac_en), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  int t0, pb, lb, hold_pops;
  int b_pop_c, b_load_c, b_mac_c, b_valid_c, b_pops, b_mac_tap;
  logic [15:0] b_load_data;
`ifdef FIR_SCHED_STATS_EN
  int st_base, acc_base;
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0; out_ready = 1'b0;
    b_enable = 1'b0; b_empty = 1'b1; b_rd_data = 16'h1111; b_ready = 1'b1;

    // 1: reset, then 100 idle cycles with an empty FIFO
    repeat (5) @(posedge clk_rd);
    #2 rst = 1'b0; enable = 1'b1;
    repeat (100) @(posedge clk_rd);
    #2;
    check("t1_no_pop", 32'(pop_cycs.size()), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);

    // 2: single sample timing
    out_ready = 1'b1; mac_cnt = 0;
    push(16'h0005);
    t0 = cyc + 1;
    wait_valid("t2_wait_valid");
    @(posedge clk_rd); #2;
    check("t2_pops", 32'(pop_cycs.size()), 32'd1);
    if (pop_cycs.size() > 0) check("t2_pop_cyc", 32'(pop_cycs[pop_cycs.size()-1] - t0), 32'd1);
    check("t2_load_cyc", 32'(load_cyc - t0), 32'd3);
    check("t2_valid_cyc", 32'(valid_rise_cyc - t0), 32'd20);
    check("t2_mac_cnt", 32'(mac_cnt), 32'd16);
    check("t2_last_tap", 32'(last_mac_tap), 32'd15);
    check("t2_smp", 32'(smp_data), 32'h5);

    // 3: three samples back-to-back
    repeat (3) @(posedge clk_rd); #2;
    pb = pop_cycs.size(); lb = load_log.size();
    push(16'd1); push(16'd2); push(16'd3);
    repeat (75) @(posedge clk_rd); #2;
    check("t3_pops", 32'(pop_cycs.size() - pb), 32'd3);
    if (pop_cycs.size() >= pb + 3) begin
      check("t3_gap1", 32'(pop_cycs[pb+1] - pop_cycs[pb]), 32'd20);
      check("t3_gap2", 32'(pop_cycs[pb+2] - pop_cycs[pb+1]), 32'd20);
    end
    if (load_log.size() >= lb + 3) begin
      check("t3_smp1", 32'(load_log[lb]), 32'd1);
      check("t3_smp2", 32'(load_log[lb+1]), 32'd2);
      check("t3_smp3", 32'(load_log[lb+2]), 32'd3);
    end
    check("t3_fifo_empty", 32'(fifo_empty), 32'd1);
    check("t3_idle", 32'(busy), 32'd0);

    // 4: result held 10 cycles by out_ready=0, FIFO still non-empty behind it
    out_ready = 1'b0;
    push(16'h000A); push(16'h000B);
`ifdef FIR_SCHED_STATS_EN
    st_base = int'(stall_count); acc_base = int'(smp_count);
`endif
    wait_valid("t4_wait_valid");
    hold_pops = pop_cycs.size();
    repeat (9) @(negedge clk_rd);
    check("t4_held", 32'(out_valid), 32'd1);
    check("t4_no_pop", 32'(pop_cycs.size() - hold_pops), 32'd0);
    @(posedge clk_rd); #2;
`ifdef FIR_SCHED_STATS_EN
    check("t4_stall10", 32'(int'(stall_count) - st_base), 32'd10);
`endif
    out_ready = 1'b1;
    @(posedge clk_rd); #2;
`ifdef FIR_SCHED_STATS_EN
    check("t4_acc1", 32'(int'(smp_count) - acc_base), 32'd1);
`endif
    repeat (25) @(posedge clk_rd); #2;

    // 5: enable dropped during MAC, then reset during MAC
    push(16'h0011); push(16'h0022);
    wait_mac("t5_wait_mac");
    @(posedge clk_rd); #2 enable = 1'b0;
    wait_valid("t5_wait_valid");
    repeat (30) @(posedge clk_rd); #2;
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_fifo_left", 32'(q.size()), 32'd1);
    enable = 1'b1;
    wait_mac("t5_wait_mac2");
    @(posedge clk_rd); #3 rst = 1'b1;
    #1;
    check("t5_rst_mac_en", 32'(mac_en), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_smp", 32'(smp_data), 32'd0);
    @(posedge clk_rd); #2 rst = 1'b0; enable = 1'b0;
    repeat (5) @(posedge clk_rd); #2;

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0 && q.size() < 6) push(16'($urandom));
      @(posedge clk_rd); #2;
    end
    enable = 1'b0; out_ready = 1'b1;
    repeat (40) @(posedge clk_rd); #2;
    check("rand_idle", 32'(busy), 32'd0);

    // 6: RD_LAT=2, NUM_TAPS=1 instance
    b_pop_c = -1; b_load_c = -1; b_mac_c = -1; b_valid_c = -1; b_pops = 0; b_mac_tap = -1;
    b_load_data = '0;
    b_empty = 1'b0; b_enable = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_rd);
      if (b_rd_en) begin b_pops++; b_pop_c = c; b_empty = 1'b1; b_enable = 1'b0; end
      if (b_pop_c >= 0 && c == b_pop_c + 2) b_rd_data = 16'hBEEF;
      if (b_load && b_load_c < 0) begin b_load_c = c; b_load_data = b_smp; end
      if (b_mac_en && b_mac_c < 0) begin b_mac_c = c; b_mac_tap = int'(b_tap); end
      if (b_valid && b_valid_c < 0) b_valid_c = c;
    end
    check("t6_pops", 32'(b_pops), 32'd1);
    check("t6_pop_cyc", 32'(b_pop_c), 32'd1);
    check("t6_load_cyc", 32'(b_load_c), 32'd4);
    check("t6_smp", 32'(b_load_data), 32'hBEEF);
    check("t6_mac_cyc", 32'(b_mac_c), 32'd5);
    check("t6_mac_tap", 32'(b_mac_tap), 32'd0);
    check("t6_valid_cyc", 32'(b_valid_c), 32'd6);
    check("t6_idle", 32'(b_busy), 32'd0);
`ifdef FIR_SCHED_STATS_EN
    check("t6_acc", 32'(b_smp_count), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
